// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial packed-BCD add/subtract datapath.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_ADJ = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bcd_state_t;

  function automatic logic bcd_bad(input bcd_digit_t x);
    return x > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decimal digit of add/subtract; subtract uses the nine's complement of b_d.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic [3:0] a_d,
  input  logic [3:0] b_d,
  input  logic       sub,
  input  logic       c_in,
  output logic [3:0] d,
  output logic       c_out,
  output logic       bad
);

  bcd_digit_t bd;
  logic [4:0] t;
  logic [4:0] t_adj;

  always_comb begin
    bd    = sub ? bcd_digit_t'(BCD_MAX - b_d) : b_d;
    t     = {1'b0, a_d} + {1'b0, bd} + {4'd0, c_in};
    t_adj = t + {1'b0, BCD_ADJ};
    if (t > {1'b0, BCD_MAX}) begin
      d     = t_adj[3:0];
      c_out = 1'b1;
    end else begin
      d     = t[3:0];
      c_out = 1'b0;
    end
    bad = bcd_bad(a_d) | bcd_bad(b_d);
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Multi-digit packed-BCD adder/subtractor, one digit per clock (LSD first)
// through a single shared digit cell, with valid/ready on both sides.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  sub,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  bcd_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]  b_sh_q, b_sh_d;
  logic          sub_q, sub_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          err_q, err_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;

  logic [3:0]    cell_d;
  logic          cell_c;
  logic          cell_bad;
  logic          any_bad;

  // Operands shift right each RUN cycle, so the active digit is always [3:0].
  bcd_digit_cell u_cell (
    .a_d   (a_sh_q[3:0]),
    .b_d   (b_sh_q[3:0]),
    .sub   (sub_q),
    .c_in  (carry_q),
    .d     (cell_d),
    .c_out (cell_c),
    .bad   (cell_bad)
  );

  always_comb begin
    any_bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      any_bad = any_bad | bcd_bad(a[4*i +: 4]) | bcd_bad(b[4*i +: 4]);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sub_d       = sub_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_sh_d     = a;
          b_sh_d     = b;
          sub_d      = sub;
          carry_d    = sub ? ~cin : cin;
          err_d      = any_bad;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (cnt_q == CW'(i)) sum_d[4*i +: 4] = cell_d;
        end
        a_sh_d  = a_sh_q >> 4;
        b_sh_d  = b_sh_q >> 4;
        carry_d = cell_c;
        err_d   = err_q | cell_bad;
        if (cnt_q == CW'(DIGITS - 1)) begin
          cout_d      = cell_c;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        cnt_d       = '0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sub_q       <= sub_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub with DIGITS=4: vector table plus
// backpressure and asynchronous mid-operation reset sequences.
module tb_bcd_serial_addsub;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W = 4 * DIGITS;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] esum;
    logic         ecout;
    logic         eerr;
  } vec_t;

  vec_t vecs[10];

  bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Applies one operand set, measures latency, checks result, then drains it.
  task automatic do_op(input vec_t v, input string tag);
    int lat;
    check({tag, " in_ready before accept"}, {31'd0, in_ready}, 32'd1);
    a = v.a; b = v.b; sub = v.sub; cin = v.cin;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, DIGITS);
    check({tag, " sum"}, {16'd0, sum}, {16'd0, v.esum});
    check({tag, " cout"}, {31'd0, cout}, {31'd0, v.ecout});
    check({tag, " err"}, {31'd0, err}, {31'd0, v.eerr});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, " in_ready rise"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0};
    vecs[1] = '{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[3] = '{16'h5000, 16'h1234, 1'b1, 1'b0, 16'h3766, 1'b1, 1'b0};
    vecs[4] = '{16'h1234, 16'h5000, 1'b1, 1'b0, 16'h6234, 1'b0, 1'b0};
    vecs[5] = '{16'h12A4, 16'h0001, 1'b0, 1'b0, 16'h1305, 1'b0, 1'b1};
    vecs[6] = '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0};
    vecs[7] = '{16'h9999, 16'h9999, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0};
    vecs[8] = '{16'h9999, 16'h9999, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b0};
    vecs[9] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    #2;
    check("reset sum", {16'd0, sum}, 32'd0);
    check("reset cout", {31'd0, cout}, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: in_valid pulses during RUN/DONE must be ignored.
    a = 16'h1234; b = 16'h5678; sub = 1'b0; cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'h9999; b = 16'h9999; sub = 1'b1; cin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp in_ready during run", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    check("bp out_valid at latency", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      check("bp hold out_valid", {31'd0, out_valid}, 32'd1);
      check("bp hold sum", {16'd0, sum}, 32'h6912);
      check("bp hold cout", {31'd0, cout}, 32'd0);
      check("bp hold in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp release in_ready", {31'd0, in_ready}, 32'd1);
    check("bp release out_valid", {31'd0, out_valid}, 32'd0);
    check("bp idle holds sum", {16'd0, sum}, 32'h6912);

    // Asynchronous reset after digit 1 of an add.
    a = 16'h1234; b = 16'h5678; sub = 1'b0; cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1 rst = 1'b1;
    #1;
    check("midrst sum", {16'd0, sum}, 32'd0);
    check("midrst cout", {31'd0, cout}, 32'd0);
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst in_ready", {31'd0, in_ready}, 32'd1);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    do_op(vecs[3], "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
